// File: rtl/traj_pkg.sv
// rtl/traj_pkg.sv - headings, sequencer states and turn-order helper
package traj_pkg;

  localparam logic [2:0] NORTE = 3'b001;
  localparam logic [2:0] OESTE = 3'b010;
  localparam logic [2:0] LESTE = 3'b011;
  localparam logic [2:0] SUL   = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    CHECA_G,
    PULSO_G,
    ESPERA_G,
    CHECA_A,
    PULSO_A,
    ESPERA_A,
    FIM
  } estado_t;

  // Turn order must match the orientation stage: N -> O -> S -> L -> N.
  function automatic logic [2:0] prox_rumo(input logic [2:0] r);
    case (r)
      NORTE:   prox_rumo = OESTE;
      OESTE:   prox_rumo = SUL;
      SUL:     prox_rumo = LESTE;
      default: prox_rumo = NORTE;
    endcase
  endfunction

  function automatic logic rumo_valido(input logic [2:0] r);
    rumo_valido = (r == NORTE) || (r == OESTE) || (r == LESTE) || (r == SUL);
  endfunction

endpackage

// File: rtl/contador_posicao.sv
// rtl/contador_posicao.sv - X/Y position counter, one unit per advance step
module contador_posicao
  import traj_pkg::*;
#(
  parameter int POS_W = 8
) (
  input  logic             c1,
  input  logic             reset,
  input  logic             passo,
  input  logic [2:0]       rumo,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y
);

  localparam logic [POS_W-1:0] UM = POS_W'(1);

  // Counters wrap modulo 2^POS_W, so 0 - 1 reads back as all ones.
  always_ff @(posedge c1) begin
    if (reset) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (passo) begin
      case (rumo)
        NORTE:   pos_y <= pos_y + UM;
        SUL:     pos_y <= pos_y - UM;
        LESTE:   pos_x <= pos_x + UM;
        OESTE:   pos_x <= pos_x - UM;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/controle_trajeto.sv
// rtl/controle_trajeto.sv - turn-then-advance motion command sequencer
module controle_trajeto
  import traj_pkg::*;
#(
  parameter int POS_W  = 8,
  parameter int STEP_W = 4,
  parameter int GAP    = 1
) (
  input  logic              c1,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_rumo,
  input  logic [STEP_W-1:0] cmd_passos,
  input  logic              abort,
  output logic              girar,
  output logic              avancar,
  output logic [2:0]        rumo,
  output logic [POS_W-1:0]  pos_x,
  output logic [POS_W-1:0]  pos_y,
  output logic              ocupado,
  output logic              done,
  output logic              erro
);

  localparam logic [3:0] GAP_FIM = 4'(GAP - 1);

  estado_t           estado, prox;
  logic [2:0]        alvo;
  logic [STEP_W-1:0] restante;
  logic [3:0]        gap_cnt;
  logic              erro_flag;
  logic              marca_erro;
  logic              fim_gap;
  logic              aceita;
  logic              em_espera;

  assign em_espera = (estado == ESPERA_G) || (estado == ESPERA_A);
  assign fim_gap   = em_espera && (gap_cnt == GAP_FIM);
  assign aceita    = (estado == IDLE) && cmd_valid;

  always_ff @(posedge c1) begin
    if (reset) begin
      estado    <= IDLE;
      rumo      <= NORTE;
      alvo      <= NORTE;
      restante  <= '0;
      gap_cnt   <= '0;
      erro_flag <= 1'b0;
    end else begin
      estado <= prox;
      if (aceita) begin
        alvo      <= cmd_rumo;
        restante  <= cmd_passos;
        erro_flag <= 1'b0;
      end
      // A pulse already on the wire still moves the shadow state, even on abort.
      if (estado == PULSO_G)
        rumo <= prox_rumo(rumo);
      if (estado == PULSO_A)
        restante <= restante - STEP_W'(1);
      if (marca_erro)
        erro_flag <= 1'b1;
      gap_cnt <= (em_espera && !fim_gap) ? gap_cnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    prox       = estado;
    marca_erro = 1'b0;
    case (estado)
      IDLE:     if (cmd_valid) prox = CHECA_G;
      CHECA_G: begin
        if (!rumo_valido(alvo)) begin
          prox       = FIM;
          marca_erro = 1'b1;
        end else if (rumo == alvo) begin
          prox = CHECA_A;
        end else begin
          prox = PULSO_G;
        end
      end
      PULSO_G:  prox = ESPERA_G;
      ESPERA_G: if (fim_gap) prox = CHECA_G;
      CHECA_A:  prox = (restante == '0) ? FIM : PULSO_A;
      PULSO_A:  prox = ESPERA_A;
      ESPERA_A: if (fim_gap) prox = CHECA_A;
      FIM:      prox = IDLE;
      default:  prox = IDLE;
    endcase
    if (abort && (estado != IDLE) && (estado != FIM)) begin
      prox       = FIM;
      marca_erro = 1'b1;
    end
  end

  assign cmd_ready = (estado == IDLE);
  assign ocupado   = (estado != IDLE);
  assign girar     = (estado == PULSO_G);
  assign avancar   = (estado == PULSO_A);
  assign done      = (estado == FIM);
  assign erro      = (estado == FIM) && erro_flag;

  contador_posicao #(
    .POS_W(POS_W)
  ) u_contador_posicao (
    .c1    (c1),
    .reset (reset),
    .passo (avancar),
    .rumo  (rumo),
    .pos_x (pos_x),
    .pos_y (pos_y)
  );

endmodule
